jt49_noise_lfsr: RTL and testbench

// Parametrised PSG noise generator, next generation of the AY-3-8910 noise block.

---
 rtl/jt49_pkg.sv | 11 +
 rtl/jt49_noise_div.sv | 50 +++++
 rtl/jt49_noise_lfsr.sv | 74 +++++++
 tb/tb_jt49_noise_lfsr.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
// rtl/jt49_pkg.sv - shared constants for the jt49 noise generator
package jt49_pkg;

    localparam int LFSR_W_AY = 17;
    localparam int TAP_AY    = 3;
    localparam int PER_W_AY  = 5;

    localparam logic NOISE_WHITE    = 1'b0;
    localparam logic NOISE_PERIODIC = 1'b1;

endpackage

// File: rtl/jt49_noise_div.sv
// rtl/jt49_noise_div.sv - noise period divider with toggle and rising-edge pulse
module jt49_noise_div
    import jt49_pkg::*;
#(
    parameter int PER_W = PER_W_AY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [PER_W-1:0] period,
    input  logic             clr,
    output logic             tog_rise
);

    logic [PER_W:0] cnt;
    logic [PER_W:0] lim;
    logic           tog;
    logic           last_tog;

    // Terminal count; a period of 0 behaves like 1, and >= lets a shrinking period wrap at once
    always_comb begin
        lim = '0;
        if (period != '0) begin
            lim = {1'b0, period} - (PER_W + 1)'(1);
        end
    end

    // Count cen cycles, flip the toggle on each wrap, and remember the previous toggle for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            tog      <= 1'b0;
            last_tog <= 1'b0;
        end else if (cen) begin
            last_tog <= tog;
            if (clr) begin
                cnt <= '0;
                tog <= 1'b0;
            end else if (cnt >= lim) begin
                cnt <= '0;
                tog <= ~tog;
            end else begin
                cnt <= cnt + (PER_W + 1)'(1);
            end
        end
    end

    assign tog_rise = tog & ~last_tog;

endmodule

// File: rtl/jt49_noise_lfsr.sv
// rtl/jt49_noise_lfsr.sv - parametrised PSG noise LFSR with white/periodic modes
module jt49_noise_lfsr
    import jt49_pkg::*;
#(
    parameter int                LFSR_W = LFSR_W_AY,
    parameter int                TAP    = TAP_AY,
    parameter int                PER_W  = PER_W_AY,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [PER_W-1:0] period,
    input  logic             mode,
    input  logic             ext_src,
    input  logic             ext_clk,
    input  logic             seed_ld,
    output logic             noise,
    output logic             step
);

    logic [LFSR_W-1:0] lfsr;
    logic              last_ext;
    logic              tog_rise;
    logic              ext_rise;
    logic              shift_en;
    logic              fb;

    jt49_noise_div #(
        .PER_W (PER_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .period   (period),
        .clr      (seed_ld),
        .tog_rise (tog_rise)
    );

    // Pick the step source and feedback; an all-zero register injects a 1 so it cannot lock up
    always_comb begin
        ext_rise = ext_clk & ~last_ext;
        shift_en = ~seed_ld & (ext_src ? ext_rise : tog_rise);
        if (mode == NOISE_PERIODIC) begin
            fb = lfsr[0];
        end else begin
            fb = lfsr[0] ^ lfsr[TAP];
        end
        fb = fb ^ (lfsr == '0);
    end

    // Shift register, external edge history, registered noise and the single-clk step pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= '0;
            last_ext <= 1'b0;
            noise    <= 1'b0;
            step     <= 1'b0;
        end else begin
            step <= 1'b0;
            if (cen) begin
                last_ext <= ext_clk;
                noise    <= ~lfsr[0];
                step     <= shift_en;
                if (seed_ld) begin
                    lfsr <= SEED;
                end else if (shift_en) begin
                    lfsr <= {fb, lfsr[LFSR_W-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_jt49_noise_lfsr.sv
// tb/tb_jt49_noise_lfsr.sv - randomized self-checking bench for jt49_noise_lfsr
module tb_jt49_noise_lfsr;

    localparam int W    = 17;
    localparam int TAPB = 3;
    localparam int PW   = 5;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          cen     = 1'b0;
    logic [PW-1:0] period  = 5'd1;
    logic          mode    = 1'b0;
    logic          ext_src = 1'b0;
    logic          ext_clk = 1'b0;
    logic          seed_ld = 1'b0;
    logic          noise;
    logic          step;

    logic          seed2 = 1'b0;
    logic          noise2;
    logic          step2;

    int n_total = 0;
    int n_bad   = 0;

    int     m_cnt;
    int     m_wraps;
    bit     m_due;
    bit     m_ext_prev;
    bit     m_noise;
    bit     m_step;
    longint m_lfsr;

    always #5 clk = ~clk;

    jt49_noise_lfsr u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .period  (period),
        .mode    (mode),
        .ext_src (ext_src),
        .ext_clk (ext_clk),
        .seed_ld (seed_ld),
        .noise   (noise),
        .step    (step)
    );

    jt49_noise_lfsr #(
        .LFSR_W (5),
        .TAP    (2),
        .PER_W  (3),
        .SEED   (5'd1)
    ) u_small (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (1'b1),
        .period  (3'd0),
        .mode    (1'b0),
        .ext_src (1'b0),
        .ext_clk (1'b0),
        .seed_ld (seed2),
        .noise   (noise2),
        .step    (step2)
    );

    task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function longint next_lfsr(input longint v, input bit md);
        bit fb;
        fb = md ? v[0] : (v[0] ^ v[TAPB]);
        if (v == 0) fb = ~fb;
        return (v >> 1) | (longint'(fb) << (W - 1));
    endfunction

    task model_reset();
        m_cnt      = 0;
        m_wraps    = 0;
        m_due      = 1'b0;
        m_ext_prev = 1'b0;
        m_noise    = 1'b0;
        m_step     = 1'b0;
        m_lfsr     = 0;
    endtask

    task model_clock();
        bit     step_now;
        int     pe;
        longint old_l;
        if (!rst_n) begin
            model_reset();
        end else if (!cen) begin
            m_step = 1'b0;
        end else begin
            old_l = m_lfsr;
            if (seed_ld) step_now = 1'b0;
            else if (ext_src) step_now = ext_clk && !m_ext_prev;
            else step_now = m_due;
            m_ext_prev = ext_clk;
            m_noise = ~old_l[0];
            pe = (period == 0) ? 1 : int'(period);
            if (seed_ld) begin
                m_cnt = 0;
                m_wraps = 0;
                m_due = 1'b0;
            end else if (m_cnt >= pe - 1) begin
                m_cnt = 0;
                m_wraps++;
                m_due = (m_wraps % 2) == 1;
            end else begin
                m_cnt++;
                m_due = 1'b0;
            end
            if (seed_ld) m_lfsr = 1;
            else if (step_now) m_lfsr = next_lfsr(old_l, mode);
            m_step = step_now;
        end
    endtask

    task tick();
        @(posedge clk);
        model_clock();
        #1;
        chk("noise", 64'(noise), 64'(m_noise));
        chk("step", 64'(step), 64'(m_step));
    endtask

    task gap(output int g);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < 200);
        g = n;
    endtask

    initial begin
        int   g;
        int   rises;
        int   steps;
        int   mism;
        int   zeros;
        int   guard;
        bit   prev2;
        bit   n0;
        bit   q2[$];
        bit   qm[$];

        model_reset();
        repeat (3) tick();
        chk("rst_noise", 64'(noise), 64'd0);
        chk("rst_step", 64'(step), 64'd0);

        rst_n = 1'b1;
        cen   = 1'b1;
        tick();
        chk("first_idle", 64'(step), 64'd0);
        tick();
        chk("first_step", 64'(step), 64'd1);
        chk("first_noise", 64'(noise), 64'd1);

        // step spacing for period 0, 1 and 5
        period = 5'd0;
        gap(g); gap(g); gap(g);
        chk("gap_p0", 64'(g), 64'd2);
        period = 5'd1;
        gap(g); gap(g); gap(g);
        chk("gap_p1", 64'(g), 64'd2);
        period = 5'd5;
        gap(g); gap(g); gap(g);
        chk("gap_p5", 64'(g), 64'd10);

        // full white sequence on a 5-bit instance
        seed2 = 1'b1;
        tick();
        seed2 = 1'b0;
        prev2 = 1'b0;
        guard = 0;
        while (q2.size() < 62 && guard < 400) begin
            tick();
            if (prev2) q2.push_back(noise2);
            prev2 = step2;
            guard++;
        end
        chk("small_len", 64'(q2.size()), 64'd62);
        if (q2.size() >= 62) begin
            mism = 0;
            zeros = 0;
            for (int i = 0; i < 31; i++) begin
                if (q2[i] != q2[i + 31]) mism++;
                if (!q2[i]) zeros++;
            end
            chk("small_first", 64'(q2[0]), 64'd1);
            chk("small_period", 64'(mism), 64'd0);
            chk("small_zeros", 64'(zeros), 64'd16);
        end

        // periodic mode from the seed
        period  = 5'd1;
        mode    = 1'b1;
        seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        prev2 = 1'b0;
        guard = 0;
        while (qm.size() < 34 && guard < 1000) begin
            tick();
            if (prev2) qm.push_back(noise);
            prev2 = step;
            guard++;
        end
        chk("per_len", 64'(qm.size()), 64'd34);
        if (qm.size() >= 34) begin
            mism = 0;
            zeros = 0;
            for (int i = 0; i < 17; i++) begin
                if (qm[i] != qm[i + 17]) mism++;
                if (!qm[i]) zeros++;
            end
            chk("per_period", 64'(mism), 64'd0);
            chk("per_zeros", 64'(zeros), 64'd1);
            chk("per_last", 64'(qm[16]), 64'd0);
        end

        // external step source
        mode    = 1'b0;
        ext_clk = 1'b0;
        ext_src = 1'b1;
        repeat (3) tick();
        rises = 0;
        steps = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) begin
                ext_clk = ~ext_clk;
                if (ext_clk) rises++;
            end
            tick();
            if (step) steps++;
        end
        ext_clk = 1'b0;
        repeat (3) begin
            tick();
            if (step) steps++;
        end
        chk("ext_steps", 64'(steps), 64'(rises));
        ext_src = 1'b0;
        repeat (4) tick();

        // seed load colliding with a due step
        period = 5'd1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_due && guard < 50);
        chk("due_found", 64'(m_due), 64'd1);
        seed_ld = 1'b1;
        tick();
        chk("seed_step", 64'(step), 64'd0);
        seed_ld = 1'b0;
        gap(g);
        chk("seed_gap", 64'(g), 64'd2);

        // clock enable freeze
        period = 5'd5;
        repeat (7) tick();
        n0  = noise;
        cen = 1'b0;
        repeat (50) tick();
        chk("freeze_noise", 64'(noise), 64'(n0));
        cen = 1'b1;
        repeat (13) tick();

        // asynchronous reset mid-count
        tick();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("arst_noise", 64'(noise), 64'd0);
        chk("arst_step", 64'(step), 64'd0);
        tick();
        rst_n = 1'b1;

        // randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            cen = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) period = PW'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            if ($urandom_range(0, 149) == 0) ext_src = ~ext_src;
            if ($urandom_range(0, 2) == 0) ext_clk = ~ext_clk;
            seed_ld = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
